vga_frame_sched: RTL

Frame-level scheduler for the VGA scan-out path. It owns the front/back framebuffer select and the write port of the 16-entry, 15-bit colormap. Buffer swaps and palette updates are requested at any time but committed only during vertical blanking, so the visible frame never tears or shows a half-updated palette. It sits between the renderer/CPU side and the pixel-clock display pipeline, and is fed by the same sx/sy counters as the colour fetch.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_frame_sched_pal_fifo.sv | 65 ++++++
 rtl/vga_frame_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Purpose: shared VGA timing constants and the palette-update entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: H_ACTIVE/V_ACTIVE/V_TOTAL shared with the timing generator and colour
// fetch; pal_entry_t carries one colormap update (index + 15-bit colour).
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef struct packed {
        logic [3:0]  idx;
        logic [14:0] color;
    } pal_entry_t;

endpackage

// File: rtl/vga_frame_sched_pal_fifo.sv
// Purpose: synchronous FIFO of pal_entry_t holding palette updates until blanking.
// Latency: push visible at the head one cycle later; pop_dat is the head, read combinationally.
// Backpressure: full/empty are decodes of the count register; push when full and pop when empty are ignored.
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat, full, empty.
module pal_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  pal_entry_t push_dat,
    input  logic       pop,
    output pal_entry_t pop_dat,
    output logic       full,
    output logic       empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    pal_entry_t          mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    // One extra bit so that a full FIFO and an empty FIFO are distinguishable.
    logic [AW:0]         count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_frame_sched.sv
// Purpose: commit framebuffer swaps and colormap updates only inside vertical blanking.
// Latency: swap_ack/front_buf one cycle after (sx=0, sy=V_ACTIVE); queued palette writes one per cycle, pal_we one cycle after each pop.
// Backpressure: pal_ready = !full of the palette FIFO, decoded from its count register (no path from the pop).
// Ports: pixel_clk, rst (sync, active-high); sx/sy scan position; swap_req -> swap_pending/swap_ack/front_buf;
// pal_valid/pal_ready/pal_idx/pal_color update stream -> pal_we/pal_wr_idx/pal_wr_color colormap write port.
module vga_frame_sched
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL   = vga_pkg::V_TOTAL,
    parameter int PAL_DEPTH = 8
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [9:0]  sx,
    input  logic [9:0]  sy,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_ack,
    output logic        front_buf,
    input  logic        pal_valid,
    output logic        pal_ready,
    input  logic [3:0]  pal_idx,
    input  logic [14:0] pal_color,
    output logic        pal_we,
    output logic [3:0]  pal_wr_idx,
    output logic [14:0] pal_wr_color
);

    // Reject geometries the 10-bit scan counters or the FIFO pointers cannot express.
    if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE >= V_TOTAL ||
        V_TOTAL > 1024 || PAL_DEPTH < 2 || (PAL_DEPTH & (PAL_DEPTH - 1)) != 0) begin : g_bad_params
        $error("vga_frame_sched: unsupported timing or PAL_DEPTH parameters");
    end

    localparam logic [9:0] VBLANK_LINE = 10'(V_ACTIVE);
    localparam logic [9:0] LAST_LINE   = 10'(V_TOTAL - 1);

    logic       vblank_entry;
    logic       drain_ok;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    pal_entry_t push_entry;
    pal_entry_t head_entry;

    assign vblank_entry = (sy == VBLANK_LINE) && (sx == 10'd0);
    // The final blanking line is left out so a registered write can never
    // land on the first visible pixel of the next frame.
    assign drain_ok     = (sy >= VBLANK_LINE) && (sy < LAST_LINE);
    assign pop          = drain_ok && !fifo_empty;
    assign pal_ready    = !fifo_full;

    assign push_entry.idx   = pal_idx;
    assign push_entry.color = pal_color;

    pal_fifo #(
        .DEPTH (PAL_DEPTH)
    ) u_pal_fifo (
        .clk      (pixel_clk),
        .rst      (rst),
        .push     (pal_valid && pal_ready),
        .push_dat (push_entry),
        .pop      (pop),
        .pop_dat  (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A request arriving on the vblank_entry cycle itself is honoured
    // immediately; a request while one is already pending is absorbed,
    // so the buffer toggles at most once per frame.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            front_buf    <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (vblank_entry && (swap_pending || swap_req)) begin
                front_buf    <= ~front_buf;
                swap_ack     <= 1'b1;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // Colormap write port: address/data hold their last value between writes.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pal_we       <= 1'b0;
            pal_wr_idx   <= '0;
            pal_wr_color <= '0;
        end else begin
            pal_we <= pop;
            if (pop) begin
                pal_wr_idx   <= head_entry.idx;
                pal_wr_color <= head_entry.color;
            end
        end
    end

endmodule
